// File: rtl/corr_accum64.sv
// corr_accum64: per-lag multiply-accumulate over 64-word history bursts,
// with bulk clear, saturating frame counter and sequential readout.
module corr_accum64 #(
   parameter int ACC_W = 32,
   parameter int FRM_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             sin,
   input  logic [7:0]       din,
   input  logic [7:0]       dshift,
   input  logic             dump_start,
   output logic             rd_valid,
   output logic [5:0]       rd_lag,
   output logic [ACC_W-1:0] rd_data,
   output logic             rd_last,
   output logic [FRM_W-1:0] frames,
   output logic             busy,
   output logic             ovf,
   output logic             drop
);

   typedef enum logic [1:0] {IDLE, ACCUM, CLEAR, DUMP} state_t;

   state_t           state, state_n;
   logic [ACC_W-1:0] mem [64];
   logic [5:0]       cnt;
   logic             pend;
   logic             v0, v1;
   logic [5:0]       lag0, lag1;
   logic [7:0]       din_r, dsh_r;
   logic [15:0]      prod1;
   logic [ACC_W-1:0] acc1;
   logic [ACC_W:0]   sum_w;
   logic [ACC_W-1:0] sum;
   logic             sat;
   logic             done;
   logic             take, lose;
   logic             start_clr, start_dump;
   logic             we;
   logic [5:0]       wa;
   logic [ACC_W-1:0] wd;

   assign busy = (state != IDLE);
   assign done = v1 && (lag1 == 6'd0);

   // Stage 2: saturating add of the product onto the lag's running sum
   always_comb begin
      sum_w = {1'b0, acc1} + {{(ACC_W-15){1'b0}}, prod1};
      sat   = sum_w[ACC_W];
      sum   = sat ? '1 : sum_w[ACC_W-1:0];
   end

   // Next state; a new burst may start once the input side of the
   // current one has drained (lag 0 in stage 0 or later)
   always_comb begin
      state_n    = state;
      take       = 1'b0;
      lose       = 1'b0;
      start_clr  = 1'b0;
      start_dump = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr || pend) begin
               start_clr = 1'b1;
               state_n   = CLEAR;
            end else if (sin) begin
               take    = 1'b1;
               state_n = ACCUM;
            end else if (dump_start) begin
               start_dump = 1'b1;
               state_n    = DUMP;
            end
         end
         ACCUM: begin
            if (sin) begin
               if ((!v0 || lag0 == 6'd0) && !pend && !clr)
                  take = 1'b1;
               else
                  lose = 1'b1;
            end
            if (done && !v0 && !take)
               state_n = IDLE;
         end
         CLEAR: begin
            lose = sin;
            if (cnt == 6'd63)
               state_n = IDLE;
         end
         DUMP: begin
            lose = sin;
            if (cnt == 6'd63)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Single write port shared by the clear sweep and stage 2
   always_comb begin
      we = v1;
      wa = lag1;
      wd = sum;
      if (state == CLEAR) begin
         we = 1'b1;
         wa = cnt;
         wd = '0;
      end
   end

   // Accumulator storage, no reset
   always_ff @(posedge clk) begin
      if (we)
         mem[wa] <= wd;
   end

   // Pipeline, lag counter, flags, frame counter and readout registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_r    <= '0;
         dsh_r    <= '0;
         v0       <= 1'b0;
         lag0     <= '0;
         v1       <= 1'b0;
         lag1     <= '0;
         prod1    <= '0;
         acc1     <= '0;
         cnt      <= '0;
         pend     <= 1'b0;
         frames   <= '0;
         ovf      <= 1'b0;
         drop     <= 1'b0;
         rd_valid <= 1'b0;
         rd_lag   <= '0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
      end else begin
         din_r <= din;
         dsh_r <= dshift;
         if (take) begin
            v0   <= 1'b1;
            lag0 <= 6'd63;
         end else if (v0 && lag0 != 6'd0) begin
            lag0 <= lag0 - 6'd1;
         end else begin
            v0 <= 1'b0;
         end
         v1    <= v0;
         lag1  <= lag0;
         prod1 <= 16'(din_r) * 16'(dsh_r);
         acc1  <= mem[lag0];
         if (start_clr || start_dump)
            cnt <= '0;
         else if (state == CLEAR || state == DUMP)
            cnt <= cnt + 6'd1;
         if (start_clr)
            pend <= 1'b0;
         else if (clr && (state == ACCUM || state == DUMP))
            pend <= 1'b1;
         if (start_clr)
            frames <= '0;
         else if (done && frames != '1)
            frames <= frames + FRM_W'(1);
         if (start_clr)
            ovf <= 1'b0;
         else if (v1 && sat)
            ovf <= 1'b1;
         if (start_clr)
            drop <= 1'b0;
         else if (lose)
            drop <= 1'b1;
         rd_valid <= (state == DUMP);
         rd_lag   <= (state == DUMP) ? cnt : 6'd0;
         rd_data  <= (state == DUMP) ? mem[cnt] : '0;
         rd_last  <= (state == DUMP) && (cnt == 6'd63);
      end
   end

endmodule

// File: tb/tb_corr_accum64.sv
// tb_corr_accum64: directed checks of corr_accum64 at ACC_W=32 and
// ACC_W=17 driven with identical stimulus.
module tb_corr_accum64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic       sin = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dshift = '0;
   logic       dump_start = 1'b0;

   logic        a_rd_valid, a_rd_last, a_busy, a_ovf, a_drop;
   logic [5:0]  a_rd_lag;
   logic [31:0] a_rd_data;
   logic [15:0] a_frames;
   logic        b_rd_valid, b_rd_last, b_busy, b_ovf, b_drop;
   logic [5:0]  b_rd_lag;
   logic [16:0] b_rd_data;
   logic [15:0] b_frames;

   corr_accum64 #(.ACC_W(32), .FRM_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .din(din),
      .dshift(dshift), .dump_start(dump_start),
      .rd_valid(a_rd_valid), .rd_lag(a_rd_lag), .rd_data(a_rd_data),
      .rd_last(a_rd_last), .frames(a_frames), .busy(a_busy),
      .ovf(a_ovf), .drop(a_drop)
   );

   corr_accum64 #(.ACC_W(17), .FRM_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sin(sin), .din(din),
      .dshift(dshift), .dump_start(dump_start),
      .rd_valid(b_rd_valid), .rd_lag(b_rd_lag), .rd_data(b_rd_data),
      .rd_last(b_rd_last), .frames(b_frames), .busy(b_busy),
      .ovf(b_ovf), .drop(b_drop)
   );

   int checks = 0;
   int passed = 0;

   logic [31:0] ga [64];
   logic [16:0] gb [64];
   int nv, first_at, last_at, seq_err, last_err, idle_err;
   logic busy_first;
   int busy_lows;

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (a_busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (a_busy !== 1'b0)
         $display("FAIL wait_idle: busy=%0b after %0d cycles, want 0", a_busy, n);
      else
         passed++;
   endtask

   task automatic burst(input logic [7:0] d, input bit flat);
      for (int j = 0; j < 64; j++) begin
         sin    = (j == 0);
         din    = d;
         dshift = flat ? 8'd255 : 8'(63 - j);
         @(negedge clk);
         if (j == 0) busy_first = a_busy;
         if (!a_busy) busy_lows++;
      end
      sin    = 1'b0;
      dshift = '0;
   endtask

   task automatic clear_run();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (64) @(negedge clk);
      wait_idle(8);
   endtask

   task automatic dump_run();
      nv = 0; first_at = 0; last_at = 0;
      seq_err = 0; last_err = 0; idle_err = 0;
      for (int k = 0; k < 64; k++) begin
         ga[k] = 32'hDEADBEEF;
         gb[k] = 17'h1BEEF;
      end
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      for (int i = 2; i <= 80; i++) begin
         @(negedge clk);
         if (a_rd_valid) begin
            if (nv == 0) first_at = i;
            last_at = i;
            if (a_rd_lag != 6'(nv)) seq_err++;
            if (a_rd_last != (nv == 63)) last_err++;
            ga[a_rd_lag] = a_rd_data;
            nv++;
         end else if (a_rd_lag != 0 || a_rd_data != 0 || a_rd_last) begin
            idle_err++;
         end
         if (b_rd_valid) gb[b_rd_lag] = b_rd_data;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({a_rd_valid, a_rd_last, a_busy, a_ovf, a_drop} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {a_rd_valid, a_rd_last, a_busy, a_ovf, a_drop});
      else passed++;
      checks++;
      if (a_rd_data !== 32'd0 || a_rd_lag !== 6'd0)
         $display("FAIL reset_rd: data=%0d lag=%0d want 0", a_rd_data, a_rd_lag);
      else passed++;
      checks++;
      if (a_frames !== 16'd0)
         $display("FAIL reset_frames: got %0d want 0", a_frames);
      else passed++;
   endtask

   task automatic test_clear_dump();
      int bad = 0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (a_busy !== 1'b1) $display("FAIL clr_busy_rise: got %0b want 1", a_busy);
      else passed++;
      repeat (63) @(negedge clk);
      checks++;
      if (a_busy !== 1'b1) $display("FAIL clr_busy_c64: got %0b want 1", a_busy);
      else passed++;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0) $display("FAIL clr_busy_c65: got %0b want 0", a_busy);
      else passed++;
      dump_run();
      for (int k = 0; k < 64; k++) if (ga[k] !== 32'd0) bad++;
      checks++;
      if (first_at != 2) $display("FAIL dump_first: at %0d want 2", first_at);
      else passed++;
      checks++;
      if (nv != 64 || last_at != 65)
         $display("FAIL dump_len: n=%0d last=%0d want 64 65", nv, last_at);
      else passed++;
      checks++;
      if (seq_err != 0 || last_err != 0 || idle_err != 0)
         $display("FAIL dump_seq: seq=%0d last=%0d idle=%0d want 0 0 0",
                  seq_err, last_err, idle_err);
      else passed++;
      checks++;
      if (bad != 0) $display("FAIL clear_zero: %0d nonzero lags want 0", bad);
      else passed++;
      checks++;
      if (a_frames !== 16'd0) $display("FAIL clear_frames: got %0d want 0", a_frames);
      else passed++;
   endtask

   task automatic test_ramp();
      int bad = 0;
      clear_run();
      burst(8'd3, 1'b0);
      checks++;
      if (busy_first !== 1'b1) $display("FAIL burst_busy_rise: got %0b want 1", busy_first);
      else passed++;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b1 || a_frames !== 16'd0)
         $display("FAIL burst_s65: busy=%0b frames=%0d want 1 0", a_busy, a_frames);
      else passed++;
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_frames !== 16'd1)
         $display("FAIL burst_s66: busy=%0b frames=%0d want 0 1", a_busy, a_frames);
      else passed++;
      dump_run();
      for (int k = 0; k < 64; k++) if (ga[k] !== 32'(3 * k)) bad++;
      checks++;
      if (bad != 0) $display("FAIL ramp_data: %0d bad lags want 0", bad);
      else passed++;
      checks++;
      if (ga[63] !== 32'd189) $display("FAIL ramp_lag63: got %0d want 189", ga[63]);
      else passed++;
      checks++;
      if (a_drop !== 1'b0) $display("FAIL ramp_drop: got %0b want 0", a_drop);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int bad_a = 0;
      int bad_b = 0;
      clear_run();
      busy_lows = 0;
      burst(8'd255, 1'b1);
      burst(8'd255, 1'b1);
      wait_idle(10);
      dump_run();
      for (int k = 0; k < 64; k++) begin
         if (ga[k] !== 32'd130050) bad_a++;
         if (gb[k] !== 17'd130050) bad_b++;
      end
      checks++;
      if (bad_a != 0 || bad_b != 0)
         $display("FAIL b2b_data: bad32=%0d bad17=%0d want 0 0", bad_a, bad_b);
      else passed++;
      checks++;
      if (a_frames !== 16'd2) $display("FAIL b2b_frames: got %0d want 2", a_frames);
      else passed++;
      checks++;
      if (a_drop !== 1'b0 || b_ovf !== 1'b0)
         $display("FAIL b2b_flags: drop=%0b ovf17=%0b want 0 0", a_drop, b_ovf);
      else passed++;
      checks++;
      if (busy_lows != 0) $display("FAIL b2b_gap: busy low %0d cycles want 0", busy_lows);
      else passed++;
   endtask

   task automatic test_saturate();
      int bad_a = 0;
      int bad_b = 0;
      clear_run();
      repeat (3) burst(8'd255, 1'b1);
      wait_idle(10);
      dump_run();
      for (int k = 0; k < 64; k++) begin
         if (ga[k] !== 32'd195075) bad_a++;
         if (gb[k] !== 17'd131071) bad_b++;
      end
      checks++;
      if (bad_b != 0) $display("FAIL sat_data17: %0d bad lags want 0", bad_b);
      else passed++;
      checks++;
      if (bad_a != 0) $display("FAIL sat_data32: %0d bad lags want 0", bad_a);
      else passed++;
      checks++;
      if (b_ovf !== 1'b1 || a_ovf !== 1'b0)
         $display("FAIL sat_ovf: ovf17=%0b ovf32=%0b want 1 0", b_ovf, a_ovf);
      else passed++;
      clear_run();
      checks++;
      if (b_ovf !== 1'b0) $display("FAIL sat_ovf_clr: got %0b want 0", b_ovf);
      else passed++;
   endtask

   task automatic test_drop_and_pending();
      int bad = 0;
      clear_run();
      burst(8'd3, 1'b0);
      wait_idle(10);
      fork
         dump_run();
         begin
            repeat (5) @(negedge clk);
            burst(8'd9, 1'b1);
         end
      join
      repeat (4) @(negedge clk);
      for (int k = 0; k < 64; k++) if (ga[k] !== 32'(3 * k)) bad++;
      checks++;
      if (bad != 0 || nv != 64) $display("FAIL drop_dump: bad=%0d n=%0d want 0 64", bad, nv);
      else passed++;
      checks++;
      if (a_drop !== 1'b1 || a_frames !== 16'd1 || a_busy !== 1'b0)
         $display("FAIL drop_flags: drop=%0b frames=%0d busy=%0b want 1 1 0",
                  a_drop, a_frames, a_busy);
      else passed++;
      fork
         burst(8'd5, 1'b1);
         begin
            repeat (10) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
         end
      join
      wait_idle(10);
      repeat (3) @(negedge clk);
      checks++;
      if (a_busy !== 1'b1) $display("FAIL pend_exec: busy=%0b want 1", a_busy);
      else passed++;
      wait_idle(80);
      dump_run();
      bad = 0;
      for (int k = 0; k < 64; k++) if (ga[k] !== 32'd0) bad++;
      checks++;
      if (bad != 0 || a_frames !== 16'd0 || a_drop !== 1'b0)
         $display("FAIL pend_clear: bad=%0d frames=%0d drop=%0b want 0 0 0",
                  bad, a_frames, a_drop);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      clear_run();
      burst(8'd3, 1'b0);
      wait_idle(10);
      for (int j = 0; j < 30; j++) begin
         sin    = (j == 0);
         din    = 8'd5;
         dshift = 8'd7;
         @(negedge clk);
      end
      sin = 1'b0;
      checks++;
      if (a_busy !== 1'b1 || a_frames !== 16'd1)
         $display("FAIL pre_rst: busy=%0b frames=%0d want 1 1", a_busy, a_frames);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({a_rd_valid, a_rd_last, a_busy, a_ovf, a_drop, b_busy} !== 6'b0 ||
          a_frames !== 16'd0 || a_rd_data !== 32'd0)
         $display("FAIL mid_rst: flags=%b frames=%0d data=%0d want 0 0 0",
                  {a_rd_valid, a_rd_last, a_busy, a_ovf, a_drop, b_busy},
                  a_frames, a_rd_data);
      else passed++;
      dshift = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_run();
      burst(8'd3, 1'b0);
      wait_idle(10);
      dump_run();
      for (int k = 0; k < 64; k++) if (ga[k] !== 32'(3 * k)) bad++;
      checks++;
      if (bad != 0 || a_frames !== 16'd1)
         $display("FAIL post_rst: bad=%0d frames=%0d want 0 1", bad, a_frames);
      else passed++;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_clear_dump();
      test_ramp();
      test_back_to_back();
      test_saturate();
      test_drop_and_pending();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
